mmio_uart_tx: RTL

//  Memory-mapped UART transmitter on the processor data bus, downstream of the arm core (DataAdr/WriteData/MemWrite).

---
 rtl/mmio_pkg.sv | 17 +
 rtl/mmio_fifo.sv | 47 ++++
 rtl/mmio_uart_tx.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register word offsets,
// STATUS bit positions and the transmit FSM state encoding.
package mmio_pkg;

    localparam logic [1:0] TXDATA_OFS  = 2'd0;
    localparam logic [1:0] STATUS_OFS  = 2'd1;
    localparam logic [1:0] BAUDDIV_OFS = 2'd2;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_CNT   = 4;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;

endpackage

// File: rtl/mmio_fifo.sv
// Synchronous FIFO with registered pointers/count; a push while full or a pop while
// empty is ignored. Read data is presented combinationally from the head entry.
module mmio_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             wr, rd;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign wr    = push & ~full;
    assign rd    = pop & ~empty;
    assign dout  = mem[rptr];

    // DEPTH is a power of two, so the pointers wrap on natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr) wptr <= wptr + 1'b1;
            if (rd) rptr <= rptr + 1'b1;
            if (wr && !rd)      count <= count + 1'b1;
            else if (rd && !wr) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wptr] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO and programmable bit period.
// Define UART_PARITY_EN to insert an even-parity bit (11-bit frame).
module mmio_uart_tx
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0080,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        sel,
    output logic        tx
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    uart_state_t   state, state_d;
    logic [15:0]   div, tmr, tmr_d;
    logic [7:0]    shift, shift_d;
    logic [2:0]    bitn, bitn_d;
    logic          tx_d, ovf, busy, bnd;
    logic          push, pop, wr_stat, wr_div;
    logic          full, empty;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] count;
    logic [31:0]   status;
    logic          unused_bits;
`ifdef UART_PARITY_EN
    logic          par;
`endif

    assign unused_bits = ^{a[1:0], wd[31:16]};

    assign sel     = (a[31:4] == BASE_ADDR[31:4]);
    assign push    = we & sel & (a[3:2] == TXDATA_OFS);
    assign wr_stat = we & sel & (a[3:2] == STATUS_OFS);
    assign wr_div  = we & sel & (a[3:2] == BAUDDIV_OFS);
    assign busy    = (state != IDLE);
    assign status  = {22'b0, 6'(count), ovf, busy, empty, full};

    always_comb begin
        rd = '0;
        if (sel) begin
            case (a[3:2])
                STATUS_OFS:  rd = status;
                BAUDDIV_OFS: rd = {16'b0, div};
                default:     rd = '0;
            endcase
        end
    end

    mmio_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (wd[7:0]),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // full is sampled before the edge, so a simultaneous pop never rescues the byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            div <= DEFAULT_DIV;
            ovf <= 1'b0;
        end else begin
            if (wr_div)            div <= (wd[15:0] == 16'd0) ? 16'd1 : wd[15:0];
            if (wr_stat && wd[ST_OVF]) ovf <= 1'b0;
            if (push && full)      ovf <= 1'b1;
        end
    end

    // Bit boundary: the timer is reloaded from div, so BAUDDIV changes apply per bit.
    assign bnd = (tmr == 16'd1);

    always_comb begin
        state_d = state;
        tx_d    = tx;
        shift_d = shift;
        bitn_d  = bitn;
        tmr_d   = tmr;
        pop     = 1'b0;
        if (state != IDLE && !bnd) tmr_d = tmr - 16'd1;
        case (state)
            IDLE: if (!empty) begin
                pop     = 1'b1;
                shift_d = fifo_dout;
                tx_d    = 1'b0;
                tmr_d   = div;
                state_d = START;
            end
            START: if (bnd) begin
                tx_d    = shift[0];
                shift_d = {1'b0, shift[7:1]};
                bitn_d  = 3'd0;
                tmr_d   = div;
                state_d = DATA;
            end
            DATA: if (bnd) begin
                tmr_d = div;
                if (bitn == 3'd7) begin
`ifdef UART_PARITY_EN
                    tx_d    = par;
                    state_d = PARITY;
`else
                    tx_d    = 1'b1;
                    state_d = STOP;
`endif
                end else begin
                    tx_d    = shift[0];
                    shift_d = {1'b0, shift[7:1]};
                    bitn_d  = bitn + 3'd1;
                end
            end
`ifdef UART_PARITY_EN
            PARITY: if (bnd) begin
                tx_d    = 1'b1;
                tmr_d   = div;
                state_d = STOP;
            end
`endif
            STOP: if (bnd) state_d = IDLE;
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            tx    <= 1'b1;
            shift <= '0;
            bitn  <= '0;
            tmr   <= '0;
        end else begin
            state <= state_d;
            tx    <= tx_d;
            shift <= shift_d;
            bitn  <= bitn_d;
            tmr   <= tmr_d;
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset)    par <= 1'b0;
        else if (pop) par <= ^fifo_dout;
    end
`endif

endmodule
